pipe_ctrl: RTL

Central pipeline controller for the 6-stage core (PC, IF, ID, EX, MEM, WB). It merges per-stage stall requests into the `stall_o` vector consumed by every pipeline register, including `id_ex` `stall_i`. It also generates per-register flushes and PC redirects for EX-resolved branch mispredicts and MEM-stage traps/MRET. It sequences trap entry over two cycles, drives the CSR trap-write strobe, and runs a MEM-stall watchdog.

---
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 6-stage core: stall merge, branch/trap/MRET flush
// and redirect, two-cycle trap/return sequencing, and a MEM-stall watchdog.
module pipe_ctrl #(
  parameter int STALL_TIMEOUT = 255,
  parameter int TIMEOUT_CAUSE = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        branch_redirect_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] exception_i,
  input  logic        mret_i,
  input  logic [31:0] mem_pc_i,
  input  logic [31:0] mem_tval_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic [5:0]  stall_o,
  output logic [5:0]  flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        trap_we_o,
  output logic [31:0] trap_cause_o,
  output logic [31:0] trap_epc_o,
  output logic [31:0] trap_tval_o,
  output logic        mret_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {RUN, TRAP, RET} state_t;

  state_t      state;
  logic [15:0] wd_cnt;
  logic [31:0] mepc_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic [31:0] tval_q;

  logic        wd_expire;
  logic        trap_take;
  logic        mret_take;
  logic        branch_take;
  logic [4:0]  exc_idx;

  // Lowest set bit wins: scan from the top so the last hit is the smallest index.
  always_comb begin
    exc_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (exception_i[i]) exc_idx = 5'(i);
    end
  end

  always_comb begin
    wd_expire   = (state == RUN) && stallreq_mem_i &&
                  (wd_cnt == 16'(STALL_TIMEOUT - 1));
    trap_take   = (state == RUN) &&
                  (((exception_i != '0) && !stallreq_mem_i) || wd_expire);
    mret_take   = (state == RUN) && mret_i && !stallreq_mem_i && !trap_take;
    branch_take = (state == RUN) && branch_redirect_i && !stallreq_ex_i &&
                  !stallreq_mem_i && !trap_take && !mret_take;
  end

  // Outputs are forced low while reset is held so a mid-TRAP reset drops every strobe.
  always_comb begin
    stall_o          = '0;
    flush_o          = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    trap_we_o        = 1'b0;
    mret_o           = 1'b0;
    timeout_o        = 1'b0;
    if (!rst_i) begin
      timeout_o = wd_expire;
      case (state)
        RUN: begin
          if (trap_take || mret_take) begin
            flush_o = 6'b011110;
            stall_o = 6'b000001;
          end else begin
            if (stallreq_mem_i)      stall_o = 6'b011111;
            else if (stallreq_ex_i)  stall_o = 6'b001111;
            else if (stallreq_id_i)  stall_o = 6'b000111;
            else if (stallreq_if_i)  stall_o = 6'b000011;
            if (branch_take) begin
              stall_o[2:0]     = 3'b000;
              flush_o          = 6'b000110;
              redirect_valid_o = 1'b1;
              redirect_pc_o    = branch_target_i;
            end
          end
        end
        TRAP: begin
          redirect_valid_o = 1'b1;
          redirect_pc_o    = mtvec_i & ~32'h3;
          trap_we_o        = 1'b1;
          flush_o          = 6'b000010;
        end
        RET: begin
          redirect_valid_o = 1'b1;
          redirect_pc_o    = mepc_q;
          mret_o           = 1'b1;
          flush_o          = 6'b000010;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= RUN;
      wd_cnt  <= '0;
      mepc_q  <= '0;
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (trap_take) begin
            state   <= TRAP;
            wd_cnt  <= '0;
            cause_q <= wd_expire ? 32'(TIMEOUT_CAUSE) : {27'd0, exc_idx};
            epc_q   <= mem_pc_i;
            tval_q  <= mem_tval_i;
          end else if (mret_take) begin
            state  <= RET;
            wd_cnt <= '0;
            mepc_q <= mepc_i;
          end else begin
            wd_cnt <= stallreq_mem_i ? wd_cnt + 16'd1 : '0;
          end
        end
        default: begin
          state  <= RUN;
          wd_cnt <= '0;
        end
      endcase
    end
  end

  assign trap_cause_o = cause_q;
  assign trap_epc_o   = epc_q;
  assign trap_tval_o  = tval_q;

endmodule
